imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Parametrised, elastic immediate generator for the decode stage. Takes a raw
//  32-bit instruction plus a format select and produces the sign-extended
//  XLEN-bit immediate. Output is DEPTH register stages later, with valid/ready
//  flow control on both sides, a pass-through tag and an illegal-format counter.
//  Sits between the fetch/decode register and the operand-select mux.
// PARAMETERS
//  XLEN   32  immediate output width; 32 or 64
//  DEPTH  1   pipeline register stages, 1..3
//  TAG_W  5   width of the pass-through tag (e.g. rd index / ROB id)
//  CNT_W  16  width of the saturating illegal-format counter
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       synchronous reset, active high
//  valid_i      in   1       input transfer request
//  ready_o      out  1       block can accept this cycle
//  instr_i      in   32      raw instruction word
//  sel_i        in   3       format select (see BEHAVIOUR)
//  tag_i        in   TAG_W   carried unchanged to tag_o
//  valid_o      out  1       output holds a result
//  ready_i      in   1       downstream accepts the result
//  imm_o        out  XLEN    generated immediate
//  illegal_o    out  1       result came from sel_i = 3'b111
//  tag_o        out  TAG_W   tag of the result
//  clr_cnt_i    in   1       synchronous clear of illegal_cnt_o
//  illegal_cnt_o out CNT_W   saturating count of illegal results delivered
// BEHAVIOUR
//  - Formats (s = instr_i[31], sign-extended to XLEN):
//    000 none -> 0 | 001 I {s,[30:20]} | 010 S {s,[30:25],[11:7]}
//    011 B {s,[7],[30:25],[11:8],0} | 100 U {s,[30:12],12'b0}
//    101 J {s,[19:12],[20],[30:21],0}
//    110 SHAMT zero-ext instr_i[24:20] (XLEN=32) / [25:20] (XLEN=64)
//    111 illegal -> imm 0, illegal bit set
//  - Immediate is computed combinationally from instr_i. It is captured into
//    stage 0 on acceptance (valid_i && ready_o). It then shifts through stages
//    0..DEPTH-1. The last stage drives the outputs.
//  - Stage k advances when its successor is empty or advancing. The last stage
//    advances on ready_i. ready_o = !v[0] || advance[0] (combinational chain).
//  - Latency: input accepted at edge N -> valid_o high after edge N+DEPTH-1 if
//    there is no stall. Throughput: 1 result per cycle while ready_i = 1.
//  - Stall: while valid_o && !ready_i, imm_o/illegal_o/tag_o are held stable.
//    At most DEPTH results are buffered. When full, ready_o = 0.
//  - Simultaneous accept and deliver in a full pipe is allowed. No bubble is
//    inserted and occupancy stays at DEPTH.
//  - Counter: +1 on each edge with valid_o && ready_i && illegal_o. It
//    saturates at all-ones, with no wrap. clr_cnt_i has priority over an
//    increment on the same edge and yields 0.
//  - Reset: on rst at any clock edge, including mid-stream, all stage valids,
//    valid_o, imm_o, illegal_o, tag_o and illegal_cnt_o go to 0. In-flight
//    results are dropped. ready_o = 1 in the first cycle after reset.
//  - Any valid_i during rst is ignored.
// TESTING
//  1 DEPTH=1, I: instr 32'hFFF00093, sel 001 -> imm_o 32'hFFFFFFFF one cycle
//    after accept. S: 32'h0020A423, sel 010 -> 32'h00000008.
//  2 B: 32'hFE000EE3, sel 011 -> 32'hFFFFFFFC. U: 32'h123450B7, sel 100 ->
//    32'h12345000. J: 32'h0080006F, sel 101 -> 32'h00000008.
//    XLEN=64: I case -> 64'hFFFFFFFFFFFFFFFF.
//  3 DEPTH=2, ready_i=0, 3 back-to-back inputs -> 2 accepted, ready_o=0 on
//    third; output stable 5 cycles. Raise ready_i -> tags delivered in order,
//    one per cycle.
//  4 Streaming 16 inputs with ready_i=1, DEPTH=3 -> 16 outputs, no gaps,
//    first at accept+2, order and tags preserved.
//  5 CNT_W=2, deliver 5 sel=111 results -> illegal_cnt_o 1,2,3,3,3. Then
//    clr_cnt_i concurrent with a 6th -> 0.
//  6 rst asserted with 2 results in flight -> valid_o=0, all outputs 0 next
//    cycle. No stale result appears after rst drops.

Source files
------------

// File: rtl/imm_gen_pipe_if.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe_if
//   Handshake/data bundle for the elastic immediate generator.
//   Upstream side : valid_i, ready_o, instr_i, sel_i, tag_i
//   Downstream side: valid_o, ready_i, imm_o, illegal_o, tag_o
//   master = the agent driving requests and accepting results
//   slave  = the immediate generator itself
// -----------------------------------------------------------------------------
interface imm_gen_pipe_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
);
   logic              valid_i;
   logic              ready_o;
   logic [31:0]       instr_i;
   logic [2:0]        sel_i;
   logic [TAG_W-1:0]  tag_i;
   logic              valid_o;
   logic              ready_i;
   logic [XLEN-1:0]   imm_o;
   logic              illegal_o;
   logic [TAG_W-1:0]  tag_o;

   modport master (
      output valid_i, instr_i, sel_i, tag_i, ready_i,
      input  ready_o, valid_o, imm_o, illegal_o, tag_o
   );

   modport slave (
      input  valid_i, instr_i, sel_i, tag_i, ready_i,
      output ready_o, valid_o, imm_o, illegal_o, tag_o
   );
endinterface

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//   Elastic immediate generator for the decode stage. Decodes the immediate of
//   a raw instruction for the selected format, sign-extends it to XLEN and
//   carries it (with illegal flag and tag) through DEPTH valid/ready register
//   stages. Bubbles collapse, so up to DEPTH results can be buffered.
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   bus (slave)     request side valid_i/ready_o/instr_i/sel_i/tag_i,
//                   result side valid_o/ready_i/imm_o/illegal_o/tag_o
//   clr_cnt_i       synchronous clear of illegal_cnt_o (wins over increment)
//   illegal_cnt_o   saturating count of illegal results delivered downstream
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 1,
   parameter int TAG_W = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   imm_gen_pipe_if.slave    bus,
   input  logic             clr_cnt_i,
   output logic [CNT_W-1:0] illegal_cnt_o
);

   // Formats: 000 none, 001 I, 010 S, 011 B, 100 U, 101 J, 110 shamt, 111 illegal.
   // The 32-bit intermediate is signed so the final size cast sign-extends.
   function automatic logic signed [XLEN-1:0] gen_imm(input logic [31:0] ins,
                                                       input logic [2:0]  sel);
      logic signed [31:0] w;
      logic               s;
      s = ins[31];
      case (sel)
         3'b001:  w = {{20{s}}, ins[31:20]};
         3'b010:  w = {{20{s}}, ins[31:25], ins[11:7]};
         3'b011:  w = {{20{s}}, ins[7], ins[30:25], ins[11:8], 1'b0};
         3'b100:  w = {ins[31:12], 12'b0};
         3'b101:  w = {{12{s}}, ins[19:12], ins[20], ins[30:21], 1'b0};
         3'b110:  w = (XLEN == 64) ? {26'b0, ins[25:20]} : {27'b0, ins[24:20]};
         default: w = '0;
      endcase
      return XLEN'(w);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   logic [DEPTH-1:0]         vld_p;
   logic [DEPTH-1:0]         adv;
   logic signed [XLEN-1:0]   imm_p [DEPTH];
   logic                     ill_p [DEPTH];
   logic [TAG_W-1:0]         tag_p [DEPTH];
   logic [CNT_W-1:0]         cnt;
   logic                     unused_opcode;

   // Opcode bits never contribute to any immediate.
   assign unused_opcode = ^bus.instr_i[6:0];

   // Stage k moves when any later stage is empty or the tail is being drained;
   // written as a closed form so each advance depends only on valids/ready_i.
   always_comb begin
      adv = '0;
      for (int k = 0; k < DEPTH; k++) begin
         adv[k] = bus.ready_i;
         for (int j = k + 1; j < DEPTH; j++) begin
            if (!vld_p[j]) adv[k] = 1'b1;
         end
      end
   end

   assign bus.ready_o = !vld_p[0] || adv[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p <= '0;
         cnt   <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            imm_p[k] <= '0;
            ill_p[k] <= 1'b0;
            tag_p[k] <= '0;
         end
      end else begin
         // ---- stage 0: capture decoded immediate on acceptance ----
         if (bus.ready_o) begin
            vld_p[0] <= bus.valid_i;
            if (bus.valid_i) begin
               imm_p[0] <= gen_imm(bus.instr_i, bus.sel_i);
               ill_p[0] <= (bus.sel_i == 3'b111);
               tag_p[0] <= bus.tag_i;
            end
         end
         // ---- stages 1..DEPTH-1: shift forward when the slot frees up ----
         for (int k = 1; k < DEPTH; k++) begin
            if (!vld_p[k] || adv[k]) begin
               vld_p[k] <= vld_p[k-1];
               if (vld_p[k-1]) begin
                  imm_p[k] <= imm_p[k-1];
                  ill_p[k] <= ill_p[k-1];
                  tag_p[k] <= tag_p[k-1];
               end
            end
         end
         // ---- output: count illegal results as they leave ----
         if (clr_cnt_i)
            cnt <= '0;
         else if (vld_p[DEPTH-1] && bus.ready_i && ill_p[DEPTH-1])
            cnt <= sat_inc(cnt);
      end
   end

   assign bus.valid_o   = vld_p[DEPTH-1];
   assign bus.imm_o     = imm_p[DEPTH-1];
   assign bus.illegal_o = ill_p[DEPTH-1];
   assign bus.tag_o     = tag_p[DEPTH-1];
   assign illegal_cnt_o = cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
//   Three instances share one stimulus stream: u0 (XLEN 32, DEPTH 1, CNT_W 2),
//   u1 (XLEN 64, DEPTH 2) and u2 (XLEN 32, DEPTH 3). Each is tracked by an
//   item-position model computed from the format rules and the elastic
//   buffering rules.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, valid_i, ready_i, clr;
   logic [31:0] instr;
   logic [2:0]  sel;
   logic [4:0]  tag;

   imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) bus0 ();
   imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) bus1 ();
   imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) bus2 ();

   logic [1:0]  cnt0;
   logic [15:0] cnt1, cnt2;

   imm_gen_pipe #(.XLEN(32), .DEPTH(1), .TAG_W(5), .CNT_W(2)) u0 (
      .clk(clk), .rst(rst), .bus(bus0.slave), .clr_cnt_i(clr), .illegal_cnt_o(cnt0));
   imm_gen_pipe #(.XLEN(64), .DEPTH(2), .TAG_W(5), .CNT_W(16)) u1 (
      .clk(clk), .rst(rst), .bus(bus1.slave), .clr_cnt_i(clr), .illegal_cnt_o(cnt1));
   imm_gen_pipe #(.XLEN(32), .DEPTH(3), .TAG_W(5), .CNT_W(16)) u2 (
      .clk(clk), .rst(rst), .bus(bus2.slave), .clr_cnt_i(clr), .illegal_cnt_o(cnt2));

   assign bus0.valid_i = valid_i; assign bus0.instr_i = instr; assign bus0.sel_i = sel;
   assign bus0.tag_i   = tag;     assign bus0.ready_i = ready_i;
   assign bus1.valid_i = valid_i; assign bus1.instr_i = instr; assign bus1.sel_i = sel;
   assign bus1.tag_i   = tag;     assign bus1.ready_i = ready_i;
   assign bus2.valid_i = valid_i; assign bus2.instr_i = instr; assign bus2.sel_i = sel;
   assign bus2.tag_i   = tag;     assign bus2.ready_i = ready_i;

   logic        ov [3], ordy [3], oill [3];
   logic [63:0] oimm [3];
   logic [4:0]  otag [3];
   logic [15:0] ocnt [3];

   assign ov[0] = bus0.valid_o; assign ordy[0] = bus0.ready_o; assign oill[0] = bus0.illegal_o;
   assign ov[1] = bus1.valid_o; assign ordy[1] = bus1.ready_o; assign oill[1] = bus1.illegal_o;
   assign ov[2] = bus2.valid_o; assign ordy[2] = bus2.ready_o; assign oill[2] = bus2.illegal_o;
   assign oimm[0] = {32'b0, bus0.imm_o}; assign oimm[1] = bus1.imm_o; assign oimm[2] = {32'b0, bus2.imm_o};
   assign otag[0] = bus0.tag_o; assign otag[1] = bus1.tag_o; assign otag[2] = bus2.tag_o;
   assign ocnt[0] = {14'b0, cnt0}; assign ocnt[1] = cnt1; assign ocnt[2] = cnt2;

   int n_cmp = 0;
   int n_bad = 0;

   // ---- reference model ----
   typedef struct {
      logic [63:0] imm;
      logic        ill;
      logic [4:0]  tag;
      int          pos;   // stage index the result currently occupies
   } item_t;

   item_t it [3][4];
   int    n    [3];
   int    mcnt [3];
   logic  acc  [3];
   logic  del  [3];

   function automatic int dep(input int d);  return d + 1;                endfunction
   function automatic int xl(input int d);   return (d == 1) ? 64 : 32;   endfunction
   function automatic int cmax(input int d); return (d == 0) ? 3 : 65535; endfunction

   // Immediate value as a plain integer: weight each field, then subtract the
   // sign weight when bit 31 is set.
   function automatic logic [63:0] ref_imm(input logic [31:0] w, input logic [2:0] s,
                                           input int xlen);
      longint v;
      case (s)
         3'd1: begin v = longint'(w[31:20]); if (w[31]) v -= 4096; end
         3'd2: begin v = longint'(w[31:25]) * 32 + longint'(w[11:7]); if (w[31]) v -= 4096; end
         3'd3: begin
            v = longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
            if (w[31]) v -= 4096;
         end
         3'd4: begin v = longint'(w[31:12]) * 4096; if (w[31]) v -= 64'sd4294967296; end
         3'd5: begin
            v = longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
            if (w[31]) v -= 1048576;
         end
         3'd6: v = (xlen == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
         default: v = 0;
      endcase
      if (xlen == 32) return {32'b0, v[31:0]};
      return 64'(v);
   endfunction

   task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", nm, obs, exp);
      end
   endtask

   // One clock: compare at the falling edge, then advance the model at the
   // rising edge, and return 1 time unit after it.
   task automatic tick();
      logic ev, er;
      int   lim, np;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         ev = (n[d] > 0) && (it[d][0].pos == dep(d) - 1);
         er = (n[d] < dep(d)) || ready_i;
         chk($sformatf("u%0d.valid_o", d), {63'b0, ov[d]}, {63'b0, ev});
         chk($sformatf("u%0d.ready_o", d), {63'b0, ordy[d]}, {63'b0, er});
         chk($sformatf("u%0d.cnt", d), {48'b0, ocnt[d]}, 64'(mcnt[d]));
         if (ev) begin
            chk($sformatf("u%0d.imm_o", d), oimm[d], it[d][0].imm);
            chk($sformatf("u%0d.illegal_o", d), {63'b0, oill[d]}, {63'b0, it[d][0].ill});
            chk($sformatf("u%0d.tag_o", d), {59'b0, otag[d]}, {59'b0, it[d][0].tag});
         end
         acc[d] = valid_i && er;
         del[d] = ev && ready_i;
      end
      @(posedge clk);
      for (int d = 0; d < 3; d++) begin
         if (rst) begin
            n[d] = 0;
            mcnt[d] = 0;
         end else begin
            if (clr) mcnt[d] = 0;
            else if (del[d] && it[d][0].ill && mcnt[d] < cmax(d)) mcnt[d]++;
            if (del[d]) begin
               for (int i = 0; i < 3; i++) it[d][i] = it[d][i+1];
               n[d]--;
            end
            for (int i = 0; i < n[d]; i++) begin
               lim = (i == 0) ? dep(d) - 1 : it[d][i-1].pos - 1;
               np  = it[d][i].pos + 1;
               it[d][i].pos = (np < lim) ? np : lim;
            end
            if (acc[d]) begin
               it[d][n[d]].imm = ref_imm(instr, sel, xl(d));
               it[d][n[d]].ill = (sel == 3'd7);
               it[d][n[d]].tag = tag;
               it[d][n[d]].pos = 0;
               n[d]++;
            end
         end
      end
      #1;
   endtask

   task automatic chk_zero(input string nm);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("%s.u%0d.valid_o", nm, d), {63'b0, ov[d]}, 64'd0);
         chk($sformatf("%s.u%0d.imm_o", nm, d), oimm[d], 64'd0);
         chk($sformatf("%s.u%0d.illegal_o", nm, d), {63'b0, oill[d]}, 64'd0);
         chk($sformatf("%s.u%0d.tag_o", nm, d), {59'b0, otag[d]}, 64'd0);
         chk($sformatf("%s.u%0d.cnt", nm, d), {48'b0, ocnt[d]}, 64'd0);
      end
   endtask

   // Single directed instruction: u0 (DEPTH 1) shows it after one edge,
   // u1 (XLEN 64, DEPTH 2) after the second.
   task automatic one(input string nm, input logic [31:0] w, input logic [2:0] s,
                      input logic [31:0] e32, input logic [63:0] e64);
      valid_i = 1'b1; instr = w; sel = s; tag = 5'd9; ready_i = 1'b1;
      tick();
      chk({nm, ".u0.valid"}, {63'b0, ov[0]}, 64'd1);
      chk({nm, ".u0.imm"}, oimm[0], {32'b0, e32});
      valid_i = 1'b0;
      tick();
      chk({nm, ".u1.imm"}, oimm[1], e64);
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin n[d] = 0; mcnt[d] = 0; end
      rst = 1'b1; valid_i = 1'b1; ready_i = 1'b0; clr = 1'b0;
      instr = 32'h0; sel = 3'd1; tag = 5'd0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
      chk_zero("reset");
      chk("reset.u2.ready_o", {63'b0, ordy[2]}, 64'd1);
      tick();

      // Format vectors
      one("I", 32'hFFF00093, 3'd1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
      one("S", 32'h0020A423, 3'd2, 32'h00000008, 64'h0000000000000008);
      one("B", 32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
      one("U", 32'h123450B7, 3'd4, 32'h12345000, 64'h0000000012345000);
      one("J", 32'h0080006F, 3'd5, 32'h00000008, 64'h0000000000000008);
      one("SH", 32'h03F00013, 3'd6, 32'h0000001F, 64'h000000000000003F);
      tick(); tick();

      // Stall with full buffers, then drain in order
      ready_i = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         valid_i = 1'b1; instr = $urandom; sel = 3'(i); tag = 5'(i);
         if (i == 3) chk("stall.u1.ready_o", {63'b0, ordy[1]}, 64'd0);
         tick();
      end
      valid_i = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      ready_i = 1'b1;
      for (int i = 0; i < 5; i++) tick();

      // Streaming
      for (int i = 0; i < 16; i++) begin
         valid_i = 1'b1; instr = $urandom; sel = 3'($urandom_range(0, 6)); tag = 5'(i);
         tick();
      end
      valid_i = 1'b0;
      for (int i = 0; i < 4; i++) tick();

      // Illegal counter saturation and clear
      for (int i = 0; i < 5; i++) begin
         valid_i = 1'b1; instr = $urandom; sel = 3'd7; tag = 5'(20 + i);
         tick();
      end
      valid_i = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("sat.u0.cnt", {48'b0, ocnt[0]}, 64'd3);
      chk("sat.u2.cnt", {48'b0, ocnt[2]}, 64'd5);
      valid_i = 1'b1; sel = 3'd7; tag = 5'd26;
      tick();
      valid_i = 1'b0; clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr.u0.cnt", {48'b0, ocnt[0]}, 64'd0);
      for (int i = 0; i < 4; i++) tick();

      // Reset mid-stream
      ready_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         valid_i = 1'b1; instr = 32'hFFF00093; sel = 3'd1; tag = 5'(10 + i);
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0; valid_i = 1'b0;
      chk_zero("midrst");
      ready_i = 1'b1;
      for (int i = 0; i < 4; i++) tick();

      // Random traffic
      for (int c = 0; c < 400; c++) begin
         valid_i = ($urandom_range(0, 3) != 0);
         ready_i = ($urandom_range(0, 2) != 0);
         instr   = $urandom;
         sel     = 3'($urandom_range(0, 7));
         tag     = 5'($urandom);
         clr     = ($urandom_range(0, 31) == 0);
         rst     = ($urandom_range(0, 96) == 0);
         tick();
      end
      rst = 1'b0; clr = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
      for (int i = 0; i < 4; i++) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
